// File: rtl/prog_load_sequencer.sv
// Load/run/dump sequencer for the accumulator processor: streams host words into
// IRAM/DRAM, runs the core under a timeout, then streams a DRAM region back out.
module prog_load_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int RUN_TIMEOUT = 65536,
    parameter int RST_HOLD    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   iram_len,
    input  logic [ADDR_W:0]   dram_len,
    input  logic [ADDR_W:0]   dump_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              core_reset,
    output logic              core_enable,
    input  logic              core_finish,
    input  logic [ADDR_W-1:0] core_dram_addr,
    input  logic [DATA_W-1:0] core_dram_wdata,
    input  logic              core_dram_we,
    input  logic              core_iram_we,
    output logic [ADDR_W-1:0] iram_addr,
    output logic [DATA_W-1:0] iram_wdata,
    output logic              iram_we,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    output logic              dram_we,
    input  logic [DATA_W-1:0] dram_rdata,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);
    localparam int CW = ADDR_W + 1;
    localparam int TW = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;
    localparam logic [CW-1:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [3:0] {
        IDLE, LOAD_I, LOAD_D, HOLD, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt, ilen, dlen, plen;
    logic [CW-1:0]  ilen_s, dlen_s, plen_s;
    logic [TW-1:0]  timer;
    logic           run_st;
    logic           unused_core_iram_we;

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] n);
        return (n > FULL) ? FULL : n;
    endfunction

    assign ilen_s = sat(iram_len);
    assign dlen_s = sat(dram_len);
    assign plen_s = sat(dump_len);

    // The core never writes IRAM through this block.
    assign unused_core_iram_we = core_iram_we;

    // Strobes are qualified by reset so an abort cycle issues no writes.
    assign run_st     = (state == RUN);
    assign in_ready   = reset && (state == LOAD_I || state == LOAD_D);
    assign iram_addr  = cnt[ADDR_W-1:0];
    assign iram_wdata = in_data;
    assign iram_we    = in_ready && in_valid && (state == LOAD_I);
    assign dram_addr  = run_st ? core_dram_addr  : cnt[ADDR_W-1:0];
    assign dram_wdata = run_st ? core_dram_wdata : in_data;
    assign dram_we    = run_st ? (core_dram_we && reset)
                               : (in_ready && in_valid && (state == LOAD_D));
    assign busy       = (state != IDLE) && (state != DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ilen        <= '0;
            dlen        <= '0;
            plen        <= '0;
            timer       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            core_reset  <= 1'b1;
            core_enable <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        done        <= 1'b0;
                        timeout_err <= 1'b0;
                        cnt         <= '0;
                        ilen        <= ilen_s;
                        dlen        <= dlen_s;
                        plen        <= plen_s;
                        if (ilen_s != '0) begin
                            state <= LOAD_I;
                        end else if (dlen_s != '0) begin
                            state <= LOAD_D;
                        end else begin
                            state       <= HOLD;
                            core_enable <= 1'b1;
                        end
                    end
                end
                LOAD_I: begin
                    if (in_valid) begin
                        if (cnt == ilen - CW'(1)) begin
                            cnt <= '0;
                            if (dlen != '0) begin
                                state <= LOAD_D;
                            end else begin
                                state       <= HOLD;
                                core_enable <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                LOAD_D: begin
                    if (in_valid) begin
                        if (cnt == dlen - CW'(1)) begin
                            cnt         <= '0;
                            state       <= HOLD;
                            core_enable <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (cnt == CW'(RST_HOLD - 1)) begin
                        cnt        <= '0;
                        timer      <= '0;
                        core_reset <= 1'b0;
                        state      <= RUN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    // Finish has priority: a simultaneous timeout is not flagged.
                    if (core_finish || timer == TW'(RUN_TIMEOUT - 1)) begin
                        timeout_err <= !core_finish;
                        core_enable <= 1'b0;
                        core_reset  <= 1'b1;
                        cnt         <= '0;
                        if (plen == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= DUMP_RD;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DUMP_RD: state <= DUMP_WAIT;
                DUMP_WAIT: begin
                    out_data  <= dram_rdata;
                    out_valid <= 1'b1;
                    state     <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (cnt == plen - CW'(1)) begin
                            cnt   <= '0;
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            cnt   <= cnt + CW'(1);
                            state <= DUMP_RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_load_sequencer.sv
// Bench for prog_load_sequencer: RAM and core models, a write/dump scoreboard
// checked every cycle, and directed load/run/dump scenarios.
module tb_prog_load_sequencer;
    localparam int AW = 4, DW = 32, RT = 16, RH = 2, DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0, start = 1'b0;
    logic [AW:0]   iram_len = '0, dram_len = '0, dump_len = '0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, core_reset, core_enable, core_finish;
    logic [DW-1:0] out_data, iram_wdata, dram_wdata, core_dram_wdata, dram_rdata;
    logic [AW-1:0] core_dram_addr, iram_addr, dram_addr;
    logic          core_dram_we, core_iram_we, iram_we, dram_we, busy, done, timeout_err;

    prog_load_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RUN_TIMEOUT(RT), .RST_HOLD(RH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .iram_len(iram_len), .dram_len(dram_len), .dump_len(dump_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .core_reset(core_reset), .core_enable(core_enable), .core_finish(core_finish),
        .core_dram_addr(core_dram_addr), .core_dram_wdata(core_dram_wdata),
        .core_dram_we(core_dram_we), .core_iram_we(core_iram_we),
        .iram_addr(iram_addr), .iram_wdata(iram_wdata), .iram_we(iram_we),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we),
        .dram_rdata(dram_rdata), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Synchronous-read RAMs
    logic [DW-1:0] iram_m[DEPTH];
    logic [DW-1:0] dram_m[DEPTH];
    always @(posedge clk) begin
        if (iram_we) iram_m[iram_addr] <= iram_wdata;
        if (dram_we) dram_m[dram_addr] <= dram_wdata;
        dram_rdata <= dram_m[dram_addr];
    end

    // Core model: counts its run cycles, writes DRAM[1] on its third cycle
    int   run_cnt = 0;
    int   finish_after = 0;
    logic core_active;
    assign core_active     = !core_reset && core_enable;
    assign core_finish     = core_active && (finish_after != 0) && (run_cnt == finish_after - 1);
    assign core_dram_we    = core_active && (run_cnt == 2);
    assign core_dram_addr  = AW'(run_cnt - 1);
    assign core_dram_wdata = 32'hC0DE_0000 + 32'(run_cnt);
    assign core_iram_we    = core_active;
    always @(posedge clk) run_cnt <= core_active ? run_cnt + 1 : 0;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    wr_t           exp_i[$], exp_d[$];
    wr_t           e_m;
    logic [DW-1:0] gold[DEPTH];
    logic [DW-1:0] cap[$];
    logic [DW-1:0] words[64];
    int            dump_idx = 0;
    int            hold_c, run_c, iw_c, dw_c, dump_c, inr_c, ov_c;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (core_enable && core_reset) hold_c++;
        if (core_active) begin
            run_c++;
            chk("run_iram_we", iram_we, 0);
            chk("run_dram_addr", dram_addr, core_dram_addr);
            chk("run_dram_we", dram_we, core_dram_we);
            chk("run_dram_wdata", dram_wdata, core_dram_wdata);
            if (core_dram_we) gold[core_dram_addr] = core_dram_wdata;
        end else begin
            if (iram_we) begin
                iw_c++;
                if (exp_i.size() == 0) chk("iram_extra_write", 1, 0);
                else begin
                    e_m = exp_i.pop_front();
                    chk("iram_addr", iram_addr, e_m.a);
                    chk("iram_data", iram_wdata, e_m.d);
                end
            end
            if (dram_we) begin
                dw_c++;
                if (exp_d.size() == 0) chk("dram_extra_write", 1, 0);
                else begin
                    e_m = exp_d.pop_front();
                    chk("dram_addr", dram_addr, e_m.a);
                    chk("dram_data", dram_wdata, e_m.d);
                    gold[e_m.a] = e_m.d;
                end
            end
        end
        if (in_ready) inr_c++;
        if (out_valid) ov_c++;
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
            dump_c++;
            cap.push_back(out_data);
            chk("dump_data", out_data, gold[AW'(dump_idx)]);
            dump_idx++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int n);
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_iram_we"}, iram_we, 0);
        chk({tag, "_dram_we"}, dram_we, 0);
        chk({tag, "_core_reset"}, core_reset, 1);
        chk({tag, "_core_enable"}, core_enable, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_words(input int n, input bit gaps);
        bit hs, ok;
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = words[i];
            ok = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                hs = in_ready;
                tick();
                if (hs) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("in_handshake_wait", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic recv_words(input int n, input int stall);
        bit ok;
        for (int i = 0; i < n; i++) begin
            ok = 1'b0;
            for (int c = 0; c < 600; c++) begin
                if (out_valid) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            if (!ok) begin
                chk("out_valid_wait", 0, 1);
                return;
            end
            repeat (stall) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic prep(input int t, input int is, input int ds);
        for (int k = 0; k < 64; k++) words[k] = 32'hA000_0000 | (32'(t) << 16) | 32'(k);
        exp_i.delete();
        exp_d.delete();
        for (int k = 0; k < is; k++) exp_i.push_back('{a: AW'(k), d: words[k]});
        for (int k = 0; k < ds; k++) exp_d.push_back('{a: AW'(k), d: words[is + k]});
        hold_c = 0; run_c = 0; iw_c = 0; dw_c = 0; dump_c = 0; inr_c = 0; ov_c = 0;
        dump_idx = 0;
        cap.delete();
    endtask

    task automatic run_test(input int t, input int il, input int dl, input int pl,
                            input int fin, input bit gaps, input int stall,
                            input bit exp_to, input int exp_run, input bit poke);
        int is, ds, ps;
        bit ok;
        is = sat(il); ds = sat(dl); ps = sat(pl);
        prep(t, is, ds);
        finish_after = fin;
        iram_len = (AW+1)'(il);
        dram_len = (AW+1)'(dl);
        dump_len = (AW+1)'(pl);
        pulse_start();
        chk("start_done_cleared", done, 0);
        chk("start_timeout_cleared", timeout_err, 0);
        chk("start_busy", busy, 1);
        fork
            send_words(is + ds, gaps);
            recv_words(ps, stall);
            begin
                if (poke) begin
                    for (int c = 0; c < 300; c++) begin
                        if (core_active) break;
                        tick();
                    end
                    repeat (3) tick();
                    pulse_start();
                    chk("ignored_start_busy", busy, 1);
                    chk("ignored_start_run", core_active, 1);
                end
            end
        join
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("done_set", ok, 1);
        chk("timeout_err", timeout_err, exp_to);
        chk("busy_end", busy, 0);
        chk("hold_cycles", hold_c, RH);
        chk("run_cycles", run_c, exp_run);
        chk("iram_writes", iw_c, is);
        chk("dram_writes", dw_c, ds);
        chk("dump_words", dump_c, ps);
        chk("iram_pending", exp_i.size(), 0);
        chk("dram_pending", exp_d.size(), 0);
        chk("end_core_reset", core_reset, 1);
        chk("end_core_enable", core_enable, 0);
        chk("end_out_valid", out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            dram_m[k] = 32'hD000_0000 + 32'(k);
            gold[k]   = 32'hD000_0000 + 32'(k);
            iram_m[k] = '0;
        end
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Nominal
        run_test(1, 4, 2, 2, 10, 1'b0, 0, 1'b0, 10, 1'b0);
        chk("nom_dump0_lit", cap.size() > 0 ? cap[0] : '0, 32'hA001_0004);
        chk("nom_dump1_lit", cap.size() > 1 ? cap[1] : '0, 32'hC0DE_0002);
        chk("nom_iram3_lit", iram_m[3], 32'hA001_0003);

        // Backpressure on both sides
        run_test(2, 3, 3, 3, 10, 1'b1, 5, 1'b0, 10, 1'b0);
        chk("bp_dump2_lit", cap.size() > 2 ? cap[2] : '0, 32'hA002_0005);

        // Core never finishes
        run_test(3, 1, 1, 3, 0, 1'b0, 0, 1'b1, RT, 1'b0);
        chk("to_dump0_lit", cap.size() > 0 ? cap[0] : '0, 32'hA003_0001);

        // All lengths zero
        run_test(4, 0, 0, 0, 10, 1'b0, 0, 1'b0, 10, 1'b0);
        chk("zero_in_ready_cycles", inr_c, 0);
        chk("zero_out_valid_cycles", ov_c, 0);

        // Reset after the first of three DRAM words
        prep(5, 0, 1);
        iram_len = '0; dram_len = (AW+1)'(3); dump_len = (AW+1)'(1);
        pulse_start();
        send_words(1, 1'b0);
        in_valid = 1'b1;
        in_data  = words[1];
        reset    = 1'b0;
        tick();
        check_reset_outputs("abort");
        reset = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("abort_dram_writes", dw_c, 1);
        chk("abort_pending", exp_d.size(), 0);
        chk("abort_idle", busy, 0);

        // Fresh run after abort
        run_test(6, 2, 2, 2, 10, 1'b0, 0, 1'b0, 10, 1'b0);
        chk("fresh_dump0_lit", cap.size() > 0 ? cap[0] : '0, 32'hA006_0002);

        // Length saturation and start ignored during RUN
        run_test(7, DEPTH + 5, 0, 1, 12, 1'b0, 0, 1'b0, 12, 1'b1);
        chk("sat_iram15_lit", iram_m[15], 32'hA007_000F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
